core_mem_arbiter: RTL
=====================

Name: core_mem_arbiter

Overview:
- Shares one data-memory channel (read and write) among the NUM_REQ per-thread LSUs of a compute core.
- Round-robin fair, one outstanding transaction at a time.
- Uses the core's valid/ready memory handshake on both sides: requester holds valid until ready, then drops it.
- Sits between the LSUs and the external memory controller channel; the scheduler's WAIT state completes once every LSU has been served through this block.

Parameters:
- NUM_REQ, 4, number of requesting LSUs (≥1, any integer, not only power of 2)
- ADDR_BITS, 8, data-memory address width
- DATA_BITS, 8, data-memory word width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  [NUM_REQ]  requester i has a pending access; held until req_ready[i] seen
- req_write  in  [NUM_REQ]  1 = write, 0 = read; stable while req_valid
- req_address  in  [NUM_REQ][ADDR_BITS]  access address
- req_wdata  in  [NUM_REQ][DATA_BITS]  write data
- req_ready  out  [NUM_REQ]  completion to requester i; held until req_valid[i] drops
- req_rdata  out  [NUM_REQ][DATA_BITS]  read result, valid while req_ready[i]=1 for a read
- mem_read_valid  out  1  read request to memory
- mem_read_address  out  ADDR_BITS  read address
- mem_read_ready  in  1  memory read complete
- mem_read_data  in  DATA_BITS  read data, sampled when mem_read_ready=1
- mem_write_valid  out  1  write request to memory
- mem_write_address  out  ADDR_BITS  write address
- mem_write_data  out  DATA_BITS  write data
- mem_write_ready  in  1  memory write complete
- busy  out  1  high whenever state ≠ ARB_IDLE

Behaviour:
- Reset value of every output is 0; rr_ptr=0; state=ARB_IDLE. All outputs are registered.
- States: ARB_IDLE, ARB_READ, ARB_WRITE, ARB_RELEASE.
- ARB_IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - On the first set bit g: latch g, req_address[g] and req_wdata[g].
  - Assert mem_write_valid (if req_write[g]) or mem_read_valid, with the address/data driven on the next edge.
  - Go to ARB_WRITE or ARB_READ.
  - No valid bits set: stay.
- ARB_READ: hold mem_read_valid and mem_read_address. On mem_read_ready:
  - mem_read_valid<=0
  - req_rdata[g]<=mem_read_data
  - req_ready[g]<=1
  - go to ARB_RELEASE
- ARB_WRITE: same as ARB_READ using the write signals; req_rdata is untouched.
- ARB_RELEASE: hold req_ready[g]=1 until req_valid[g]=0. Then:
  - req_ready[g]<=0
  - rr_ptr<=(g+1) mod NUM_REQ (explicit compare-to-wrap, no power-of-2 assumption)
  - go to ARB_IDLE
- Latency: req_valid high at edge N (arbiter idle) gives mem_*_valid high after edge N. Memory ready at edge M gives req_ready high after edge M. Minimum full handshake is 4 cycles.
- Latched address/data are used for the whole transaction; requester changes after grant are ignored.
- At most one of mem_read_valid/mem_write_valid is high; never both.
- A requester dropping req_valid before grant is not served.
- A requester dropping req_valid after grant does not abort: the memory transaction completes, ARB_RELEASE sees valid low, and the arbiter returns to IDLE next cycle. req_ready pulses for one cycle.
- Requests arriving during a transaction wait; no request is lost while its valid is held.
- Fairness: with all NUM_REQ requesting continuously, each is served exactly once per NUM_REQ grants.
- Asynchronous reset mid-transaction drops mem_*_valid and req_ready at once. The memory side must tolerate the abandoned request.
- req_rdata[i] retains its last value until the next read by requester i.

Test Plan:
- Single read: req_valid[2]=1, req_write[2]=0, addr 0x1A; memory answers ready after 3 cycles with data 0x5C -> mem_read_address=0x1A; req_ready[2]=1 with req_rdata[2]=0x5C; released after valid drops; rr_ptr=3.
- Single write: requester 0 writes 0x77 to 0x40 -> mem_write_valid=1, mem_write_address=0x40, mem_write_data=0x77; mem_read_valid stays 0 throughout; req_ready[0] follows mem_write_ready.
- Contention: all 4 request reads at once with rr_ptr=0 -> grant order 0,1,2,3; a second round from rr_ptr=2 (valid bits 0,1,3) -> order 3,0,1.
- Wrap with NUM_REQ=3: grant to requester 2 -> rr_ptr returns to 0; requesters 0 and 2 pending -> 0 is served first.
- Early drop: requester 1 drops req_valid while in ARB_READ -> read still completes, req_ready[1] is high for exactly 1 cycle, arbiter returns to IDLE.
- Reset mid-operation: assert reset during ARB_WRITE, between clock edges -> mem_write_valid, req_ready and busy go to 0 immediately; after release, a new request proceeds normally from rr_ptr=0.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory read/write channel among NUM_REQ LSUs.
// One transaction in flight at a time; valid/ready handshakes on both sides.
module core_mem_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]   req_address,
  input  logic [NUM_REQ-1:0][DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0][DATA_BITS-1:0]   req_rdata,
  output logic                                mem_read_valid,
  output logic [ADDR_BITS-1:0]                mem_read_address,
  input  logic                                mem_read_ready,
  input  logic [DATA_BITS-1:0]                mem_read_data,
  output logic                                mem_write_valid,
  output logic [ADDR_BITS-1:0]                mem_write_address,
  output logic [DATA_BITS-1:0]                mem_write_data,
  input  logic                                mem_write_ready,
  output logic                                busy
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_READ,
    ARB_WRITE,
    ARB_RELEASE
  } state_e;

  state_e                              state_q, state_d;
  logic [GW-1:0]                       grant_q, grant_d;
  logic [GW-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]                  ready_q, ready_d;
  logic [NUM_REQ-1:0][DATA_BITS-1:0]   rdata_q, rdata_d;
  logic                                rd_vld_q, rd_vld_d;
  logic [ADDR_BITS-1:0]                rd_addr_q, rd_addr_d;
  logic                                wr_vld_q, wr_vld_d;
  logic [ADDR_BITS-1:0]                wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]                wr_data_q, wr_data_d;
  logic                                busy_q, busy_d;

  logic                                pick_vld;
  logic [GW-1:0]                       pick_idx;

  // First pending requester at or after rr_ptr, wrapping by compare-and-subtract.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!pick_vld && req_valid[GW'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = GW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    ready_d   = ready_q;
    rdata_d   = rdata_q;
    rd_vld_d  = rd_vld_q;
    rd_addr_d = rd_addr_q;
    wr_vld_d  = wr_vld_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          if (req_write[pick_idx]) begin
            wr_vld_d  = 1'b1;
            wr_addr_d = req_address[pick_idx];
            wr_data_d = req_wdata[pick_idx];
            state_d   = ARB_WRITE;
          end else begin
            rd_vld_d  = 1'b1;
            rd_addr_d = req_address[pick_idx];
            state_d   = ARB_READ;
          end
        end
      end
      ARB_READ: begin
        if (mem_read_ready) begin
          rd_vld_d         = 1'b0;
          rdata_d[grant_q] = mem_read_data;
          ready_d[grant_q] = 1'b1;
          state_d          = ARB_RELEASE;
        end
      end
      ARB_WRITE: begin
        if (mem_write_ready) begin
          wr_vld_d         = 1'b0;
          ready_d[grant_q] = 1'b1;
          state_d          = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        // Completion is held until the requester withdraws, then the pointer advances past it.
        if (!req_valid[grant_q]) begin
          ready_d[grant_q] = 1'b0;
          rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      ready_q   <= '0;
      rdata_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign req_ready         = ready_q;
  assign req_rdata         = rdata_q;
  assign mem_read_valid    = rd_vld_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_vld_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign busy              = busy_q;

endmodule
